acc_readout: RTL and testbench
==============================

ACC_READOUT -- requirements
Module: acc_readout

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter LEN_W, default 8, width of cfg_len.
REQ-003 SHALL have parameter SAT_W, default 20, signed result width used only when saturation is compiled in.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_len  input  LEN_W  beats per group minus one, sampled on a group's first beat.
REQ-007 SHALL have ports in_valid/in_ready  input/output  1/1  product-beat handshake.
REQ-008 SHALL have port in_data  input  28  signed product beat.
REQ-009 SHALL have port acc_a  output  28  accumulator addend (drives accumulator A_i).
REQ-010 SHALL have port acc_aac  output  1  accumulate-enable (drives accumulator aac).
REQ-011 SHALL have port acc_out  input  28  accumulator result {MSB half, LSB half}.
REQ-012 SHALL have ports res_valid/res_ready  output/input  1/1  result handshake.
REQ-013 SHALL have port res_data  output  28  group sum, FIFO head.
REQ-014 SHALL have port res_sat  output  1  head entry was clamped (tied 0 without macro).

Function
REQ-015 SHALL run FSM IDLE (no group open) -> ACC (on first accepted beat, unless group length 1) -> IDLE after last accepted beat; group length 1 stays IDLE.
REQ-016 SHALL latch len_q = cfg_len on first beat; beat counter clears on first beat, increments per accepted beat; last beat when counter == len_q.
REQ-017 SHALL drive acc_a = in_data and acc_aac = 0 for an accepted first beat; acc_a = in_data, acc_aac = 1 for accepted later beats.
REQ-018 SHALL, in ACC with no accepted beat (bubble), drive acc_a = 0, acc_aac = 1 so the running sum holds.
REQ-019 SHALL drive acc_a = 0, acc_aac = 0 in IDLE with no accepted beat.
REQ-020 SHALL set pend = 1 the cycle after a last beat is accepted and push acc_out into FIFO in that cycle (latency: last beat at cycle t -> push at t+1 -> res_valid at t+2).
REQ-021 SHALL drive in_ready = (fifo_count + pend) < DEPTH; ignores same-cycle pop (conservative).
REQ-022 SHALL allow a new group's first beat in the push cycle (back-to-back groups, zero bubbles).
REQ-023 SHALL pop when res_valid && res_ready; simultaneous push and pop leaves count unchanged.
REQ-024 SHALL hold res_data stable while res_valid && !res_ready.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH; full never overwritten, empty never popped.

Reset
REQ-026 SHALL on reset: FSM IDLE, counter 0, len_q 0, pend 0, FIFO empty, res_valid 0, res_data 0, res_sat 0, in_ready 1, acc_a 0, acc_aac 0.
REQ-027 SHALL discard an open group and any pending capture on reset mid-group; the accumulator is reset in the same cycle by the integrator.

Configuration
REQ-028 SHALL, with ACC_READOUT_SAT_EN defined, clamp each pushed sum to [-2^(SAT_W-1), 2^(SAT_W-1)-1], sign-extend to 28 bits, store a per-entry sat bit driven on res_sat.
REQ-029 SHALL, without ACC_READOUT_SAT_EN, push acc_out unmodified and tie res_sat to 0.

Structure
REQ-030 SHALL place ACC_W=28, half width 14, FSM state enum and saturation limit function in shared package acc_pkg.
REQ-031 SHALL implement the FIFO as sub-module acc_res_fifo (DEPTH, data+sat); FSM, counter, addend mux in top.

Verification
REQ-032 SHALL cover cfg_len=3, beats 1,2,3,4, res_ready=1 -> one result 10, res_valid two cycles after beat 4.
REQ-033 SHALL cover cfg_len=0, beats -5,7 -> results -5 then 7, acc_aac=0 both beats.
REQ-034 SHALL cover cfg_len=2, beats 0x3FFF,1,2 with bubble after beat 1 -> result 0x4002 (carry across 14-bit boundary), bubble acc_a=0 acc_aac=1.
REQ-035 SHALL cover res_ready=0, 5 groups of length 1 -> 4 results held, in_ready low once count+pend=4, fifth accepted after one pop, order preserved.
REQ-036 SHALL cover SAT_EN, SAT_W=20, cfg_len=1, beats 0x7FFFF,0x7FFFF -> res_data 0x007FFFF, res_sat=1; without macro -> 0x00FFFFE, res_sat=0.
REQ-037 SHALL cover reset asserted mid-group after 2 of 4 beats -> FIFO empty, no result, next group sums from zero.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared widths, FSM encoding and the saturation helper for the accumulator readout block.
package acc_pkg;
   localparam int HALF_W = 14;
   localparam int ACC_W  = 2 * HALF_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_t;

   // Returns {clamped, value}: value limited to sat_w signed bits, sign-extended to ACC_W.
   function automatic logic [ACC_W:0] sat_limit(input logic [ACC_W-1:0] v, input int sat_w);
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      logic signed [ACC_W-1:0] sv;
      hi = $signed((ACC_W'(1) << (sat_w - 1)) - ACC_W'(1));
      lo = ~hi;
      sv = $signed(v);
      if (sv > hi) begin
         return {1'b1, hi};
      end else if (sv < lo) begin
         return {1'b1, lo};
      end
      return {1'b0, v};
   endfunction
endpackage

// File: rtl/acc_res_fifo.sv
// Result FIFO for group sums: registered storage, head shown combinationally, zero when empty.
// Pushes into a full FIFO and pops from an empty one are ignored.
module acc_res_fifo
   import acc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ACC_W + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [W-1:0]           i_push_dat,
   input  logic                   i_pop,
   output logic [W-1:0]           o_head_dat,
   output logic                   o_head_vld,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && (r_count != (AW+1)'(DEPTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   assign o_head_vld = (r_count != '0);
   assign o_head_dat = o_head_vld ? r_mem[r_rd_ptr] : '0;
   assign o_count    = r_count;
endmodule

// File: rtl/acc_readout.sv
// Steers product beats into an external accumulator and queues each group sum; result valid 2 cycles after last beat.
// in_ready drops when queued+pending results fill DEPTH. Define ACC_READOUT_SAT_EN to clamp sums to SAT_W bits.
module acc_readout
   import acc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LEN_W = 8,
   parameter int SAT_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ACC_W-1:0] in_data,
   output logic [ACC_W-1:0] acc_a,
   output logic             acc_aac,
   input  logic [ACC_W-1:0] acc_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             res_sat
);
   localparam int CW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SAT_W < 2 || SAT_W > ACC_W) begin : g_param_check
      $error("acc_readout: DEPTH must be a power of two >= 2 and SAT_W within 2..ACC_W");
   end

   acc_state_t       r_state;
   acc_state_t       w_state_nxt;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] w_cnt_nxt;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] w_len_nxt;
   logic             r_pend;
   logic             w_accept;
   logic             w_first;
   logic             w_last;
   logic [CW-1:0]    w_count;
   logic [ACC_W:0]   w_push_dat;
   logic [ACC_W:0]   w_head_dat;

   // A sum still waiting to be captured already owns a FIFO slot.
   assign in_ready = (int'(w_count) + int'(r_pend)) < DEPTH;
   assign w_accept = in_valid && in_ready && !reset;
   assign w_first  = (r_state == ST_IDLE);
   assign w_last   = w_accept && (w_first ? (cfg_len == '0) : (r_cnt == r_len));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      acc_a       = '0;
      acc_aac     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               acc_a     = in_data;
               w_len_nxt = cfg_len;
               w_cnt_nxt = LEN_W'(1);
               if (!w_last) w_state_nxt = ST_ACC;
            end
         end
         ST_ACC: begin
            acc_aac = !reset;
            if (w_accept) begin
               acc_a     = in_data;
               w_cnt_nxt = r_cnt + LEN_W'(1);
               if (w_last) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_len   <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_len   <= w_len_nxt;
         r_pend  <= w_last;
      end
   end

`ifdef ACC_READOUT_SAT_EN
   assign w_push_dat = sat_limit(acc_out, SAT_W);
`else
   assign w_push_dat = {1'b0, acc_out};
`endif

   acc_res_fifo #(
      .DEPTH (DEPTH),
      .W     (ACC_W + 1)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (r_pend),
      .i_push_dat (w_push_dat),
      .i_pop      (res_valid && res_ready),
      .o_head_dat (w_head_dat),
      .o_head_vld (res_valid),
      .o_count    (w_count)
   );

   assign res_data = w_head_dat[ACC_W-1:0];
   assign res_sat  = w_head_dat[ACC_W];
endmodule

// File: tb/tb_acc_readout.sv
// Directed bench for acc_readout with an external accumulator model and a group-sum scoreboard.
module tb_acc_readout;
   localparam int DEPTH = 4;
   localparam int LEN_W = 8;
   localparam int SAT_W = 20;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [27:0]      in_data = '0;
   logic [27:0]      acc_a;
   logic             acc_aac;
   logic [27:0]      acc_out;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [27:0]      res_data;
   logic             res_sat;

   acc_readout #(.DEPTH(DEPTH), .LEN_W(LEN_W), .SAT_W(SAT_W)) dut (
      .clk(clk), .reset(reset), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .acc_a(acc_a), .acc_aac(acc_aac), .acc_out(acc_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_sat(res_sat)
   );

   always #5 clk = ~clk;

   // The accumulator the block drives: load on aac=0, add on aac=1.
   logic [27:0] r_acc;
   always @(posedge clk) begin
      if (reset) r_acc <= '0;
      else if (acc_aac) r_acc <= r_acc + acc_a;
      else r_acc <= acc_a;
   end
   assign acc_out = r_acc;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [28:0] model_result(input longint sum);
      logic [27:0] w;
`ifdef ACC_READOUT_SAT_EN
      longint s;
      longint lim;
`endif
      w = sum[27:0];
`ifdef ACC_READOUT_SAT_EN
      s   = longint'($signed(w));
      lim = longint'(1) << (SAT_W - 1);
      if (s > lim - 1) return {1'b1, 28'(lim - 1)};
      if (s < -lim) return {1'b1, 28'(-lim)};
`endif
      return {1'b0, w};
   endfunction

   // Scoreboard: group sums computed from accepted beats, in order.
   bit          mon_en = 0;
   bit          m_open = 0;
   int          m_idx;
   int          m_len;
   longint      m_sum;
   logic [28:0] exp_q[$];
   logic [28:0] got_q[$];
   bit          hold_vld = 0;
   logic [27:0] hold_dat;

   always @(negedge clk) begin : mon
      bit beat;
      logic [28:0] e;
      if (mon_en) begin
         if (reset) begin
            m_open = 0;
            exp_q.delete();
            hold_vld = 0;
            chk("rst_acc_a", acc_a, 0);
            chk("rst_acc_aac", acc_aac, 0);
         end else begin
            beat = in_valid && in_ready;
            chk("in_ready", in_ready, exp_q.size() < DEPTH);
            chk("acc_a", acc_a, beat ? in_data : 28'd0);
            chk("acc_aac", acc_aac, m_open);
            if (hold_vld) begin
               chk("hold_valid", res_valid, 1);
               chk("hold_data", res_data, hold_dat);
            end
            hold_vld = res_valid && !res_ready;
            hold_dat = res_data;
            if (res_valid && res_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", res_data, 28'hDEAD);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_data", res_data, e[27:0]);
                  chk("res_sat", res_sat, e[28]);
               end
               got_q.push_back({res_sat, res_data});
            end
            if (beat) begin
               if (!m_open) begin
                  m_len = int'(cfg_len);
                  m_idx = 0;
                  m_sum = 0;
               end
               m_sum += longint'($signed(in_data));
               if (m_idx == m_len) begin
                  exp_q.push_back(model_result(m_sum));
                  m_open = 0;
               end else begin
                  m_open = 1;
                  m_idx++;
               end
            end
         end
      end
   end

   task automatic send_beat(input logic [27:0] d, input bit exp_aac);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      chk("beat_acc_a", acc_a, d);
      chk("beat_acc_aac", acc_aac, exp_aac);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_got(input int n);
      int c;
      c = 0;
      while (got_q.size() < n && c < 50) begin
         @(posedge clk);
         c++;
      end
      #1;
      if (got_q.size() < n) chk("result_timeout", got_q.size(), n);
   endtask

   task automatic chk_got(input string name, input int i, input logic [27:0] d, input bit s);
      logic [28:0] g;
      if (got_q.size() <= i) begin
         chk(name, got_q.size(), i + 1);
      end else begin
         g = got_q[i];
         chk(name, g[27:0], d);
         chk({name, "_sat"}, g[28], s);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_res_valid", res_valid, 0);
      chk("reset_res_data", res_data, 0);
      chk("reset_res_sat", res_sat, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_acc_a", acc_a, 0);
      chk("reset_acc_aac", acc_aac, 0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1;

      // Four-beat group, latency from last beat to result.
      got_q.delete();
      cfg_len = 8'd3;
      send_beat(28'd1, 0);
      send_beat(28'd2, 1);
      send_beat(28'd3, 1);
      send_beat(28'd4, 1);
      @(negedge clk);
      chk("t1_valid_at_push", res_valid, 0);
      @(negedge clk);
      chk("t1_valid_after", res_valid, 1);
      chk("t1_data", res_data, 28'd10);
      wait_got(1);
      chk_got("t1_result", 0, 28'd10, 0);

      // Single-beat groups back to back.
      got_q.delete();
      cfg_len = 8'd0;
      send_beat(28'hFFFFFFB, 0);
      send_beat(28'd7, 0);
      wait_got(2);
      chk_got("t2_first", 0, 28'hFFFFFFB, 0);
      chk_got("t2_second", 1, 28'd7, 0);

      // Carry across the half boundary with a bubble mid-group.
      got_q.delete();
      cfg_len = 8'd2;
      send_beat(28'h3FFF, 0);
      send_beat(28'd1, 1);
      @(negedge clk);
      chk("t3_bubble_acc_a", acc_a, 0);
      chk("t3_bubble_acc_aac", acc_aac, 1);
      @(posedge clk);
      #1;
      send_beat(28'd2, 1);
      wait_got(1);
      chk_got("t3_result", 0, 28'h4002, 0);

      // Fill the FIFO with the consumer stalled.
      got_q.delete();
      res_ready = 1'b0;
      cfg_len = 8'd0;
      for (int i = 0; i < 4; i++) send_beat(28'(11 + i), 0);
      @(negedge clk);
      chk("t4_in_ready_full", in_ready, 0);
      chk("t4_head_valid", res_valid, 1);
      chk("t4_head_data", res_data, 28'd11);
      @(negedge clk);
      chk("t4_in_ready_still_full", in_ready, 0);
      chk("t4_head_held", res_data, 28'd11);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      send_beat(28'd15, 0);
      res_ready = 1'b1;
      wait_got(5);
      for (int i = 0; i < 5; i++) chk_got("t4_order", i, 28'(11 + i), 0);

      // Sum above the saturation range.
      got_q.delete();
      cfg_len = 8'd1;
      send_beat(28'h7FFFF, 0);
      send_beat(28'h7FFFF, 1);
      wait_got(1);
`ifdef ACC_READOUT_SAT_EN
      chk_got("t5_sat", 0, 28'h007FFFF, 1);
`else
      chk_got("t5_nosat", 0, 28'h00FFFFE, 0);
`endif

      // Reset in the middle of a group.
      got_q.delete();
      cfg_len = 8'd3;
      send_beat(28'd5, 0);
      send_beat(28'd6, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("t6_res_valid", res_valid, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_acc_aac", acc_aac, 0);
      repeat (4) @(negedge clk);
      chk("t6_no_result", got_q.size(), 0);
      @(posedge clk);
      #1;
      cfg_len = 8'd1;
      send_beat(28'd20, 0);
      send_beat(28'd22, 1);
      wait_got(1);
      chk_got("t6_after_reset", 0, 28'd42, 0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
